// File: rtl/icache.sv
// icache: direct-mapped, one-word-per-line instruction cache in front of the byte-serial memory controller.
module icache #(
    parameter int INDEX_BITS = 7,
    parameter int TAG_BITS   = 32 - INDEX_BITS - 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_fetch_ena,
    input  logic [31:0] in_fetch_addr,
    input  logic        in_flush,
    output logic        out_fetch_ok,
    output logic [31:0] out_fetch_inst,
    output logic        out_mem_ena,
    output logic [31:0] out_mem_addr,
    input  logic        in_mem_ok,
    input  logic [31:0] in_mem_data
);
    localparam int LINES = 2 ** INDEX_BITS;
    typedef enum logic {IDLE, MISS} state_t;
    state_t state_q, state_d;
    logic discard_q, discard_d;
    logic ok_q, ok_d;
    logic [31:0] inst_q, inst_d;
    logic [31:2] addr_q, addr_d;
    logic [LINES-1:0] valid_q;
    logic [TAG_BITS-1:0] tag_q [LINES];
    logic [31:0] data_q [LINES];
    logic [INDEX_BITS-1:0] fetch_idx, miss_idx;
    logic [TAG_BITS-1:0] fetch_tag, miss_tag;
    logic hit, fill;
    logic unused_lsb;
    assign unused_lsb = ^in_fetch_addr[1:0];
    assign fetch_idx = in_fetch_addr[INDEX_BITS+1:2];
    assign fetch_tag = in_fetch_addr[31:INDEX_BITS+2];
    assign miss_idx = addr_q[INDEX_BITS+1:2];
    assign miss_tag = addr_q[31:INDEX_BITS+2];
    assign hit = valid_q[fetch_idx] && tag_q[fetch_idx] == fetch_tag;
    assign fill = state_q == MISS && in_mem_ok;
    // Dropped in the return cycle so the controller never sees a second read.
    assign out_mem_ena = state_q == MISS && !in_mem_ok;
    assign out_mem_addr = {addr_q, 2'b00};
    assign out_fetch_ok = ok_q;
    assign out_fetch_inst = inst_q;
    always_comb begin
        state_d = state_q;
        discard_d = discard_q;
        ok_d = 1'b0;
        inst_d = inst_q;
        addr_d = addr_q;
        if (state_q == IDLE) begin
            if (in_fetch_ena && !in_flush) begin
                if (hit) begin
                    ok_d = 1'b1;
                    inst_d = data_q[fetch_idx];
                end else begin
                    addr_d = in_fetch_addr[31:2];
                    discard_d = 1'b0;
                    state_d = MISS;
                end
            end
        end else begin
            discard_d = discard_q || in_flush;
            if (in_mem_ok) begin
                state_d = IDLE;
                ok_d = !discard_q && !in_flush;
                inst_d = ok_d ? in_mem_data : inst_q;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            discard_q <= 1'b0;
            ok_q <= 1'b0;
            inst_q <= '0;
            addr_q <= '0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            discard_q <= discard_d;
            ok_q <= ok_d;
            inst_q <= inst_d;
            addr_q <= addr_d;
            if (fill) valid_q[miss_idx] <= 1'b1;
        end
    end
    // A flushed miss still fills: the controller cannot abort the read.
    always_ff @(posedge clk) begin
        if (fill) begin
            tag_q[miss_idx] <= miss_tag;
            data_q[miss_idx] <= in_mem_data;
        end
    end
endmodule

// File: tb/tb_icache.sv
// tb_icache: directed checks of hit/miss, conflict eviction, flush during miss, busy controller and reset.
module tb_icache;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_fetch_ena = 1'b0;
    logic [31:0] in_fetch_addr = '0;
    logic in_flush = 1'b0;
    logic out_fetch_ok;
    logic [31:0] out_fetch_inst;
    logic out_mem_ena;
    logic [31:0] out_mem_addr;
    logic in_mem_ok = 1'b0;
    logic [31:0] in_mem_data = '0;
    int n_cmp = 0;
    int n_bad = 0;

    icache dut (
        .clk(clk),
        .rst(rst),
        .in_fetch_ena(in_fetch_ena),
        .in_fetch_addr(in_fetch_addr),
        .in_flush(in_flush),
        .out_fetch_ok(out_fetch_ok),
        .out_fetch_inst(out_fetch_inst),
        .out_mem_ena(out_mem_ena),
        .out_mem_addr(out_mem_addr),
        .in_mem_ok(in_mem_ok),
        .in_mem_data(in_mem_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_fetch(input logic [31:0] a);
        in_fetch_ena = 1'b1;
        in_fetch_addr = a;
        tick();
        in_fetch_ena = 1'b0;
        #1;
    endtask

    // Controller answers in cycle n after the request is first seen.
    task automatic mem_reply(input int n, input logic [31:0] d, input logic [31:0] a);
        for (int i = 1; i < n; i++) begin
            chk("mem_ena_held", {31'b0, out_mem_ena}, 32'd1);
            chk("mem_addr_stable", out_mem_addr, a);
            tick();
            #1;
        end
        in_mem_ok = 1'b1;
        in_mem_data = d;
        #1;
        chk("mem_ena_low_in_ok", {31'b0, out_mem_ena}, 32'd0);
        tick();
        in_mem_ok = 1'b0;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        tick();
        tick();
        chk("rst_ok", {31'b0, out_fetch_ok}, 32'd0);
        chk("rst_inst", out_fetch_inst, 32'd0);
        chk("rst_mem_ena", {31'b0, out_mem_ena}, 32'd0);
        chk("rst_mem_addr", out_mem_addr, 32'd0);
        rst = 1'b0;
        tick();
        // 1 cold miss
        do_fetch(32'h0000_1000);
        chk("cold_ok", {31'b0, out_fetch_ok}, 32'd0);
        mem_reply(5, 32'h0000_0413, 32'h0000_1000);
        chk("cold_ok_pulse", {31'b0, out_fetch_ok}, 32'd1);
        chk("cold_inst", out_fetch_inst, 32'h0000_0413);
        chk("cold_mem_ena_after", {31'b0, out_mem_ena}, 32'd0);
        tick();
        chk("cold_ok_one_cycle", {31'b0, out_fetch_ok}, 32'd0);
        chk("cold_inst_hold", out_fetch_inst, 32'h0000_0413);
        // 2 warm hit, low address bits ignored
        do_fetch(32'h0000_1002);
        chk("hit_ok", {31'b0, out_fetch_ok}, 32'd1);
        chk("hit_inst", out_fetch_inst, 32'h0000_0413);
        chk("hit_no_mem", {31'b0, out_mem_ena}, 32'd0);
        tick();
        chk("hit_no_mem_later", {31'b0, out_mem_ena}, 32'd0);
        chk("hit_ok_one_cycle", {31'b0, out_fetch_ok}, 32'd0);
        // 3 conflict at the same index
        do_fetch(32'h0000_1200);
        chk("conf_miss", {31'b0, out_mem_ena}, 32'd1);
        mem_reply(2, 32'h1111_1111, 32'h0000_1200);
        chk("conf_inst", out_fetch_inst, 32'h1111_1111);
        do_fetch(32'h0000_1000);
        chk("conf_evicted", {31'b0, out_mem_ena}, 32'd1);
        mem_reply(3, 32'h0000_0413, 32'h0000_1000);
        chk("conf_refill_ok", {31'b0, out_fetch_ok}, 32'd1);
        chk("conf_refill_inst", out_fetch_inst, 32'h0000_0413);
        // flush wins over a same-cycle fetch in IDLE
        in_flush = 1'b1;
        do_fetch(32'h0000_4000);
        in_flush = 1'b0;
        chk("idle_flush_ok", {31'b0, out_fetch_ok}, 32'd0);
        chk("idle_flush_mem", {31'b0, out_mem_ena}, 32'd0);
        // 4 flush during miss
        do_fetch(32'h0000_2000);
        tick();
        in_flush = 1'b1;
        tick();
        in_flush = 1'b0;
        #1;
        chk("flush_req_kept", {31'b0, out_mem_ena}, 32'd1);
        mem_reply(2, 32'hDEAD_BEEF, 32'h0000_2000);
        chk("flush_no_ok", {31'b0, out_fetch_ok}, 32'd0);
        chk("flush_inst_hold", out_fetch_inst, 32'h0000_0413);
        do_fetch(32'h0000_2000);
        chk("flush_fill_hit", {31'b0, out_fetch_ok}, 32'd1);
        chk("flush_fill_inst", out_fetch_inst, 32'hDEAD_BEEF);
        // flush coinciding with the return cycle
        do_fetch(32'h0000_5008);
        in_flush = 1'b1;
        mem_reply(1, 32'h5555_AAAA, 32'h0000_5008);
        in_flush = 1'b0;
        chk("okflush_no_ok", {31'b0, out_fetch_ok}, 32'd0);
        do_fetch(32'h0000_5008);
        chk("okflush_fill_hit", out_fetch_inst, 32'h5555_AAAA);
        // 5 busy controller
        do_fetch(32'h0000_3004);
        mem_reply(21, 32'hCAFE_F00D, 32'h0000_3004);
        chk("busy_ok", {31'b0, out_fetch_ok}, 32'd1);
        chk("busy_inst", out_fetch_inst, 32'hCAFE_F00D);
        tick();
        chk("busy_single_req", {31'b0, out_mem_ena}, 32'd0);
        do_fetch(32'h0000_3004);
        chk("busy_hit", {31'b0, out_mem_ena}, 32'd0);
        chk("busy_hit_ok", {31'b0, out_fetch_ok}, 32'd1);
        // 6 reset mid-miss clears valid and outputs
        do_fetch(32'h0000_6000);
        rst = 1'b1;
        tick();
        chk("rst2_ok", {31'b0, out_fetch_ok}, 32'd0);
        chk("rst2_inst", out_fetch_inst, 32'd0);
        chk("rst2_mem_ena", {31'b0, out_mem_ena}, 32'd0);
        chk("rst2_mem_addr", out_mem_addr, 32'd0);
        rst = 1'b0;
        tick();
        do_fetch(32'h0000_1000);
        chk("rst2_miss", {31'b0, out_mem_ena}, 32'd1);
        chk("rst2_miss_addr", out_mem_addr, 32'h0000_1000);
        mem_reply(2, 32'h0000_0413, 32'h0000_1000);
        chk("rst2_fill_inst", out_fetch_inst, 32'h0000_0413);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
